// File: rtl/mux_nway_scan_if.sv
// Output stream of the N-way scan mux.
// Master drives data/channel/valid; slave returns ready.
interface mux_nway_scan_if #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 3
);
  logic [WIDTH-1:0] out_data;
  logic [SEL_W-1:0] out_chan;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_chan,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_chan,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/mux_nway_scan.sv
// Registered N-way W-bit mux with valid/ready output.
// Manual mode emits one beat; scan mode walks every channel then pulses done.
module mux_nway_scan #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH*CHANNELS-1:0] in_bus,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      start,
  mux_nway_scan_if.master           bus,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {
    IDLE,
    MAN,
    SCAN
  } state_t;

  localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] cap_idx;
  logic [WIDTH-1:0] cap_data;
  logic [WIDTH-1:0] term [CHANNELS];
  logic             hs;

  assign hs = bus.out_valid & bus.out_ready;

  // IDLE captures the requested channel; SCAN captures the next one.
  always_comb begin
    cap_idx = ptr + SEL_W'(1);
    if (state == IDLE) begin
      cap_idx = mode ? '0 : sel;
    end
  end

  // Out-of-range indices match no channel and select zero.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_term
    assign term[k] = in_bus[k*WIDTH +: WIDTH]
                   & {WIDTH{cap_idx == SEL_W'(k)}};
  end

  always_comb begin
    cap_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      cap_data = cap_data | term[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= '0;
      bus.out_data  <= '0;
      bus.out_chan  <= '0;
      bus.out_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bus.out_data  <= cap_data;
            bus.out_chan  <= cap_idx;
            bus.out_valid <= 1'b1;
            busy          <= 1'b1;
            ptr           <= '0;
            state         <= mode ? SCAN : MAN;
          end
        end
        MAN: begin
          if (hs) begin
            bus.out_valid <= 1'b0;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        SCAN: begin
          if (hs) begin
            if (ptr == LAST) begin
              bus.out_valid <= 1'b0;
              busy          <= 1'b0;
              done          <= 1'b1;
              state         <= IDLE;
            end else begin
              ptr          <= cap_idx;
              bus.out_chan <= cap_idx;
              bus.out_data <= cap_data;
            end
          end
        end
        default: begin
          bus.out_valid <= 1'b0;
          busy          <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_nway_scan.sv
// Directed bench for mux_nway_scan: 8-channel and 6-channel instances.
// Channel k drives 16'h1000+k unless deliberately overwritten.
module tb_mux_nway_scan;

  logic clk = 1'b0;
  logic reset;

  logic [16*8-1:0] in8;
  logic [2:0]      sel8;
  logic            mode8, start8, busy8, done8;

  logic [16*6-1:0] in6;
  logic [2:0]      sel6;
  logic            mode6, start6, busy6, done6;

  int checks = 0;
  int errors = 0;

  mux_nway_scan_if #(.WIDTH(16), .SEL_W(3)) bus8 ();
  mux_nway_scan_if #(.WIDTH(16), .SEL_W(3)) bus6 ();

  mux_nway_scan #(.WIDTH(16), .CHANNELS(8), .SEL_W(3)) dut8 (
    .clk(clk), .reset(reset), .in_bus(in8), .sel(sel8),
    .mode(mode8), .start(start8), .bus(bus8.master),
    .busy(busy8), .done(done8)
  );

  mux_nway_scan #(.WIDTH(16), .CHANNELS(6), .SEL_W(3)) dut6 (
    .clk(clk), .reset(reset), .in_bus(in6), .sel(sel6),
    .mode(mode6), .start(start6), .bus(bus6.master),
    .busy(busy6), .done(done6)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [16*8-1:0] pat8();
    logic [16*8-1:0] r;
    for (int k = 0; k < 8; k++) r[k*16 +: 16] = 16'h1000 + 16'(k);
    return r;
  endfunction

  function automatic logic [16*6-1:0] pat6();
    logic [16*6-1:0] r;
    for (int k = 0; k < 6; k++) r[k*16 +: 16] = 16'h1000 + 16'(k);
    return r;
  endfunction

  function automatic logic [16*8-1:0] junk8(input int c);
    logic [16*8-1:0] r;
    for (int k = 0; k < 8; k++) r[k*16 +: 16] = 16'hD000 + 16'(c*16 + k);
    return r;
  endfunction

  int pat [16] = '{1,0,0,1,0,1,1,0,0,0,1,0,1,1,1,0};

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int beat;
    int dcnt;
    int r;

    in8 = pat8(); in6 = pat6();
    sel8 = 0; mode8 = 0; start8 = 0;
    sel6 = 0; mode6 = 0; start6 = 0;
    bus8.out_ready = 1'b0;
    bus6.out_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // reset state
    chk("rst_valid", 32'(bus8.out_valid), 1'b0);
    chk("rst_data",  32'(bus8.out_data), 16'h0);
    chk("rst_chan",  32'(bus8.out_chan), 3'd0);
    chk("rst_busy",  32'(busy8), 1'b0);
    chk("rst_done",  32'(done8), 1'b0);
    chk("rst6_valid", 32'(bus6.out_valid), 1'b0);

    // 1: manual sel=5
    start8 = 1; mode8 = 0; sel8 = 5; bus8.out_ready = 1;
    @(negedge clk);
    start8 = 0;
    chk("t1_valid", 32'(bus8.out_valid), 1'b1);
    chk("t1_data",  32'(bus8.out_data), 16'h1005);
    chk("t1_chan",  32'(bus8.out_chan), 3'd5);
    chk("t1_busy",  32'(busy8), 1'b1);
    @(negedge clk);
    chk("t1_valid_end", 32'(bus8.out_valid), 1'b0);
    chk("t1_busy_end",  32'(busy8), 1'b0);
    chk("t1_done_end",  32'(done8), 1'b0);

    // 2: full scan, ready held high
    start8 = 1; mode8 = 1;
    @(negedge clk);
    start8 = 0;
    for (int i = 0; i < 8; i++) begin
      chk("t2_valid", 32'(bus8.out_valid), 1'b1);
      chk("t2_data",  32'(bus8.out_data), 32'(16'h1000 + i));
      chk("t2_chan",  32'(bus8.out_chan), 32'(i));
      chk("t2_done_mid", 32'(done8), 1'b0);
      @(negedge clk);
    end
    chk("t2_done",  32'(done8), 1'b1);
    chk("t2_valid_end", 32'(bus8.out_valid), 1'b0);
    chk("t2_busy_end",  32'(busy8), 1'b0);
    @(negedge clk);
    chk("t2_done_once", 32'(done8), 1'b0);

    // 3: stalls with in_bus rewritten while stalled
    beat = 0; dcnt = 0;
    start8 = 1; mode8 = 1;
    @(negedge clk);
    start8 = 0;
    for (int c = 0; c < 80 && dcnt == 0; c++) begin
      if (bus8.out_valid) begin
        chk("t3_data", 32'(bus8.out_data), 32'(16'h1000 + beat));
        chk("t3_chan", 32'(bus8.out_chan), 32'(beat));
      end
      if (done8) dcnt++;
      r = pat[c % 16];
      bus8.out_ready = (r != 0);
      in8 = (r != 0) ? pat8() : junk8(c);
      if (bus8.out_valid && r != 0) beat++;
      if (dcnt == 0) @(negedge clk);
    end
    chk("t3_beats", 32'(beat), 32'd8);
    chk("t3_done_cnt", 32'(dcnt), 32'd1);
    in8 = pat8();
    bus8.out_ready = 1;
    @(negedge clk);
    chk("t3_done_once", 32'(done8), 1'b0);

    // 4: start pulse mid-scan is ignored
    start8 = 1; mode8 = 1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      chk("t4_data", 32'(bus8.out_data), 32'(16'h1000 + i));
      chk("t4_chan", 32'(bus8.out_chan), 32'(i));
      if (i == 2) begin
        start8 = 1; mode8 = 0; sel8 = 3;
      end else begin
        start8 = 0;
      end
      @(negedge clk);
    end
    start8 = 0;
    chk("t4_done", 32'(done8), 1'b1);
    @(negedge clk);

    // 5: reset while beat 4 is valid
    start8 = 1; mode8 = 1;
    @(negedge clk);
    start8 = 0;
    repeat (4) @(negedge clk);
    chk("t5_chan4", 32'(bus8.out_chan), 3'd4);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("t5_valid", 32'(bus8.out_valid), 1'b0);
    chk("t5_data",  32'(bus8.out_data), 16'h0);
    chk("t5_chan",  32'(bus8.out_chan), 3'd0);
    chk("t5_busy",  32'(busy8), 1'b0);
    chk("t5_done",  32'(done8), 1'b0);
    dcnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done8) dcnt++;
    end
    chk("t5_no_done", 32'(dcnt), 32'd0);
    start8 = 1; mode8 = 1;
    @(negedge clk);
    start8 = 0;
    chk("t5_restart_valid", 32'(bus8.out_valid), 1'b1);
    chk("t5_restart_data",  32'(bus8.out_data), 16'h1000);
    chk("t5_restart_chan",  32'(bus8.out_chan), 3'd0);
    repeat (9) @(negedge clk);
    chk("t5_drained", 32'(busy8), 1'b0);

    // 6: CHANNELS=6, out-of-range manual select
    start6 = 1; mode6 = 0; sel6 = 7; bus6.out_ready = 0;
    @(negedge clk);
    start6 = 0;
    chk("t6_oor_valid", 32'(bus6.out_valid), 1'b1);
    chk("t6_oor_data",  32'(bus6.out_data), 16'h0);
    chk("t6_oor_chan",  32'(bus6.out_chan), 3'd7);
    @(negedge clk);
    chk("t6_oor_hold", 32'(bus6.out_valid), 1'b1);
    bus6.out_ready = 1;
    @(negedge clk);
    chk("t6_oor_end", 32'(bus6.out_valid), 1'b0);

    // 6: start in the done cycle is accepted
    start6 = 1; mode6 = 1;
    @(negedge clk);
    start6 = 0;
    for (int i = 0; i < 6; i++) begin
      chk("t6_data", 32'(bus6.out_data), 32'(16'h1000 + i));
      chk("t6_chan", 32'(bus6.out_chan), 32'(i));
      @(negedge clk);
    end
    chk("t6_done", 32'(done6), 1'b1);
    chk("t6_done_valid", 32'(bus6.out_valid), 1'b0);
    start6 = 1; mode6 = 1;
    @(negedge clk);
    start6 = 0;
    chk("t6_b2b_valid", 32'(bus6.out_valid), 1'b1);
    chk("t6_b2b_data",  32'(bus6.out_data), 16'h1000);
    chk("t6_b2b_chan",  32'(bus6.out_chan), 3'd0);
    chk("t6_b2b_busy",  32'(busy6), 1'b1);
    repeat (7) @(negedge clk);
    chk("t6_b2b_idle", 32'(busy6), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
